// File: rtl/max_unpool_stream.sv
// max_unpool_stream: re-expands one pooled winner (value + original slot)
// into a frame of 2^N words, with the value at its slot and FILL elsewhere.
// Valid/ready on both sides; a new word can be taken on the last beat of
// the current frame so consecutive frames run without a bubble.
module max_unpool_stream #(
  parameter int            W    = 16,
  parameter int            N    = 4,
  parameter logic [W-1:0]  FILL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_value,
  input  logic [N-1:0] in_index,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_pos,
  output logic         out_last,
  output logic         busy
);

  localparam logic [N-1:0] POS_LAST = {N{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] pos;
  logic [N-1:0] index_r;
  logic [W-1:0] value_r;

  logic         emit;
  logic         at_last;
  logic         in_hs;
  logic         out_hs;

  // Word for the current slot: the captured winner at its slot, FILL elsewhere
  // and whenever no frame is being emitted.
  function automatic logic [W-1:0] slot_word(input logic         active,
                                             input logic [N-1:0] slot,
                                             input logic [N-1:0] idx,
                                             input logic [W-1:0] val);
    return (active && (slot == idx)) ? val : FILL;
  endfunction

  // Output decode from state; everything is forced quiet while rst_n is low
  // so nothing downstream sees a half-aborted frame. in_ready passes out_ready
  // through on the last beat to allow back-to-back frames.
  always_comb begin
    emit      = rst_n && (state == EMIT);
    at_last   = (pos == POS_LAST);
    out_valid = emit;
    out_last  = emit && at_last;
    out_pos   = emit ? pos : '0;
    out_data  = slot_word(emit, pos, index_r, value_r);
    busy      = emit;
    in_ready  = rst_n && ((state == IDLE) || (at_last && out_ready));
    in_hs     = in_valid && in_ready;
    out_hs    = emit && out_ready;
  end

  // Frame FSM: capture on input handshake (restarting at slot 0), advance the
  // slot on each accepted beat, return to IDLE after the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pos     <= '0;
      value_r <= '0;
      index_r <= '0;
    end else if (in_hs) begin
      value_r <= in_value;
      index_r <= in_index;
      pos     <= '0;
      state   <= EMIT;
    end else if (out_hs) begin
      if (at_last) begin
        state <= IDLE;
        pos   <= '0;
      end else begin
        pos <= pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_max_unpool_stream.sv
// Bench for max_unpool_stream: two instances share all stimulus, one with
// FILL=0 and one with FILL=0xDEAD, and both are compared on every beat.
module tb_max_unpool_stream;

  localparam logic [15:0] FILL0 = 16'h0000;
  localparam logic [15:0] FILL1 = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_value;
  logic [3:0]  in_index;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [15:0] out_data0;
  logic [3:0]  out_pos0;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [15:0] out_data1;
  logic [3:0]  out_pos1;

  always #5 clk = ~clk;

  max_unpool_stream #(.W(16), .N(4), .FILL(FILL0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_value(in_value), .in_index(in_index), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_pos(out_pos0),
    .out_last(out_last0), .busy(busy0)
  );

  max_unpool_stream #(.W(16), .N(4), .FILL(FILL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_value(in_value), .in_index(in_index), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_pos(out_pos1),
    .out_last(out_last1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  index;
    logic [15:0] exp_first0;
    logic [15:0] exp_last0;
    logic [15:0] exp_last1;
  } vec_t;

  vec_t vecs [4];

  int checks = 0;
  int errors = 0;

  int          p;
  int          beats;
  int          stall;
  logic        hs_pending;
  logic [15:0] first0, last0, last1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_beat(input int pos, input logic [15:0] val, input logic [3:0] idx);
    logic win;
    win = (pos == int'(idx));
    chk("valid0", 32'(out_valid0), 32'd1);
    chk("valid1", 32'(out_valid1), 32'd1);
    chk("pos0", 32'(out_pos0), 32'(pos));
    chk("pos1", 32'(out_pos1), 32'(pos));
    chk("data0", 32'(out_data0), 32'(win ? val : FILL0));
    chk("data1", 32'(out_data1), 32'(win ? val : FILL1));
    chk("last0", 32'(out_last0), 32'(pos == 15));
    chk("last1", 32'(out_last1), 32'(pos == 15));
    chk("busy0", 32'(busy0), 32'd1);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid0"}, 32'(out_valid0), 32'd0);
    chk({name, "_valid1"}, 32'(out_valid1), 32'd0);
    chk({name, "_busy0"}, 32'(busy0), 32'd0);
    chk({name, "_ready0"}, 32'(in_ready0), 32'd1);
    chk({name, "_data0"}, 32'(out_data0), 32'(FILL0));
    chk({name, "_data1"}, 32'(out_data1), 32'(FILL1));
  endtask

  // One isolated frame with out_ready held high; inputs are scrambled after
  // the handshake to show they are ignored.
  task automatic run_frame(input logic [15:0] val, input logic [3:0] idx,
                           output logic [15:0] f0, output logic [15:0] l0,
                           output logic [15:0] l1);
    f0 = 'x; l0 = 'x; l1 = 'x;
    @(negedge clk);
    in_valid = 1'b1; in_value = val; in_index = idx; out_ready = 1'b1;
    #1;
    chk("accept_ready0", 32'(in_ready0), 32'd1);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      in_valid = 1'b0; in_value = ~val; in_index = ~idx;
      #1;
      check_beat(b, val, idx);
      chk("frame_in_ready", 32'(in_ready0), 32'(b == 15));
      if (b == 0) f0 = out_data0;
      if (b == 15) begin
        l0 = out_data0;
        l1 = out_data1;
      end
    end
    @(negedge clk);
    #1;
    check_idle("after_frame");
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'd5,  16'h0000, 16'h0000, 16'hDEAD};
    vecs[1] = '{16'hFFFF, 4'd0,  16'hFFFF, 16'h0000, 16'hDEAD};
    vecs[2] = '{16'h8001, 4'd15, 16'h0000, 16'h8001, 16'h8001};
    vecs[3] = '{16'h0000, 4'd10, 16'h0000, 16'h0000, 16'hDEAD};

    rst_n = 1'b0; in_valid = 1'b0; in_value = 16'h0; in_index = 4'h0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_out_last", 32'(out_last0), 32'd0);
    chk("rst_out_pos", 32'(out_pos0), 32'd0);
    chk("rst_data0", 32'(out_data0), 32'(FILL0));
    chk("rst_data1", 32'(out_data1), 32'(FILL1));
    chk("rst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check_idle("post_rst");

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].value, vecs[v].index, first0, last0, last1);
      chk("tbl_first0", 32'(first0), 32'(vecs[v].exp_first0));
      chk("tbl_last0", 32'(last0), 32'(vecs[v].exp_last0));
      chk("tbl_last1", 32'(last1), 32'(vecs[v].exp_last1));
    end

    // Backpressure: stall three cycles at slot 7
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h00AA; in_index = 4'd7; out_ready = 1'b1;
    #1;
    p = 0; beats = 0; stall = 0;
    for (int c = 0; c < 40 && p < 16; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = !(p == 7 && stall < 3);
      #1;
      check_beat(p, 16'h00AA, 4'd7);
      if (!out_ready) stall++;
      else begin
        p++;
        beats++;
      end
    end
    chk("bp_beats", 32'(beats), 32'd16);
    chk("bp_stalls", 32'(stall), 32'd3);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_idle("bp_end");

    // Back-to-back: second word held until taken on the first frame's last beat
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h0001; in_index = 4'd2; out_ready = 1'b1;
    #1;
    hs_pending = in_valid && in_ready0;
    chk("b2b_first_accept", 32'(hs_pending), 32'd1);
    p = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (hs_pending) begin
        if (p == 0) begin
          in_value = 16'h0002; in_index = 4'd9;
        end else begin
          in_valid = 1'b0;
        end
        p++;
      end
      #1;
      check_beat(k % 16, (k < 16) ? 16'h0001 : 16'h0002, (k < 16) ? 4'd2 : 4'd9);
      chk("b2b_in_ready", 32'(in_ready0), 32'((k % 16) == 15));
      hs_pending = in_valid && in_ready0;
    end
    chk("b2b_accepts", 32'(p), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_idle("b2b_end");

    // Reset mid-frame at slot 6
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h1234; in_index = 4'd5; out_ready = 1'b1;
    #1;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_beat(b, 16'h1234, 4'd5);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_low", 32'(in_ready0), 32'd0);
    chk("midrst_valid_low", 32'(out_valid0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle("midrst_after");
    chk("midrst_pos", 32'(out_pos0), 32'd0);
    run_frame(16'h5555, 4'd3, first0, last0, last1);
    chk("midrst_first0", 32'(first0), 32'h0000);
    chk("midrst_last1", 32'(last1), 32'hDEAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
